// File: rtl/clock_enable_generator.sv
// Multi-channel tick / clock-enable generator: each channel divides CLK by a
// run-time programmable ratio, emitting a one-cycle TICK and a 50% SQ wave.
module clock_enable_generator #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned CNT_W  = 27,
   parameter int unsigned CH_W   = 4,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
      {27'd100_000_000, 27'd50_000_000, 27'd100_000}
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EN,
   input  logic              SYNC,
   input  logic              WR,
   input  logic [CH_W-1:0]   WR_CH,
   input  logic [CNT_W-1:0]  WR_DIV,
   output logic [NUM_CH-1:0] TICK,
   output logic [NUM_CH-1:0] SQ
);

   logic [CNT_W-1:0]  div_q [NUM_CH];
   logic [CNT_W-1:0]  div_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] sq_q, sq_d;

   // Next state: SYNC overrides a write, a write overrides counting.
   always_comb begin
      logic [CNT_W-1:0] eff_div;
      logic             wr_hit;
      eff_div = '0;
      wr_hit  = 1'b0;
      tick_d  = '0;
      sq_d    = sq_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         div_d[i] = div_q[i];
         cnt_d[i] = cnt_q[i];
         // A zero divisor behaves as divide-by-one so the channel never stalls.
         eff_div  = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];
         wr_hit   = WR && (WR_CH == CH_W'(i));
         if (wr_hit) begin
            div_d[i] = WR_DIV;
         end
         if (SYNC) begin
            cnt_d[i] = '0;
            sq_d[i]  = 1'b0;
         end else if (wr_hit) begin
            cnt_d[i] = '0;
         end else if (EN) begin
            if (cnt_q[i] == eff_div - CNT_W'(1)) begin
               cnt_d[i]  = '0;
               tick_d[i] = 1'b1;
               sq_d[i]   = ~sq_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
            cnt_q[i] <= '0;
         end
         tick_q <= '0;
         sq_q   <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            div_q[i] <= div_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign TICK = tick_q;
   assign SQ   = sq_q;

endmodule

// File: tb/tb_clock_enable_generator.sv
// Bench for clock_enable_generator: an edge-counting reference model checked
// every cycle, plus directed literal checks at known edges.
module tb_clock_enable_generator;

   localparam int unsigned NUM_CH = 3;
   localparam int unsigned CNT_W  = 27;
   localparam int unsigned CH_W   = 4;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              EN = 1'b0;
   logic              SYNC = 1'b0;
   logic              WR = 1'b0;
   logic [CH_W-1:0]   WR_CH = '0;
   logic [CNT_W-1:0]  WR_DIV = '0;
   logic [NUM_CH-1:0] TICK;
   logic [NUM_CH-1:0] SQ;

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   clock_enable_generator #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .CH_W    (CH_W),
      .DIV_INIT({27'd3, 27'd2, 27'd4})
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (EN),
      .SYNC  (SYNC),
      .WR    (WR),
      .WR_CH (WR_CH),
      .WR_DIV(WR_DIV),
      .TICK  (TICK),
      .SQ    (SQ)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: enabled edges since the last restart, n; the channel
   // ticks whenever n is a multiple of d and SQ flips once per completed d.
   int unsigned       n    [NUM_CH];
   int unsigned       mdiv [NUM_CH];
   logic [NUM_CH-1:0] exp_tick = '0;
   logic [NUM_CH-1:0] exp_sq   = '0;
   logic [NUM_CH-1:0] sq_base  = '0;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         mdiv[0] = 4; mdiv[1] = 2; mdiv[2] = 3;
         for (int i = 0; i < NUM_CH; i++) n[i] = 0;
         exp_tick = '0;
         exp_sq   = '0;
         sq_base  = '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            bit          hit;
            int unsigned d;
            hit = WR && (int'(WR_CH) == i);
            if (hit) mdiv[i] = int'(WR_DIV);
            d = (mdiv[i] == 0) ? 1 : mdiv[i];
            if (SYNC) begin
               n[i] = 0; sq_base[i] = 1'b0; exp_sq[i] = 1'b0; exp_tick[i] = 1'b0;
            end else if (hit) begin
               n[i] = 0; sq_base[i] = exp_sq[i]; exp_tick[i] = 1'b0;
            end else if (EN) begin
               n[i]++;
               exp_tick[i] = (n[i] % d) == 0;
               exp_sq[i]   = sq_base[i] ^ 1'((n[i] / d) % 2);
            end else begin
               exp_tick[i] = 1'b0;
            end
         end
      end
   end

   always @(negedge CLK) begin
      if (started) begin
         chk("model_tick", 32'(TICK), 32'(exp_tick));
         chk("model_sq",   32'(SQ),   32'(exp_sq));
      end
   end

   task automatic step(input int k);
      repeat (k) @(posedge CLK);
      #2;
   endtask

   task automatic wr_pulse(input int ch, input int dv, input bit sync);
      WR = 1'b1; WR_CH = CH_W'(ch); WR_DIV = CNT_W'(dv); SYNC = sync;
      step(1);
      WR = 1'b0; SYNC = 1'b0;
   endtask

   initial begin
      logic [11:0] m0, m1, m2;
      m0 = 12'b1000_1000_1000;
      m1 = 12'b1010_1010_1010;
      m2 = 12'b1001_0010_0100;

      #1 RST = 1'b1;
      started = 1'b1;
      EN = 1'b1;
      step(3);
      chk("reset_tick", 32'(TICK), 32'd0);
      chk("reset_sq",   32'(SQ),   32'd0);
      RST = 1'b0;

      // Reset divisors {4,2,3}: fixed tick pattern over the first 12 edges.
      for (int k = 1; k <= 12; k++) begin
         step(1);
         chk("init_tick0", 32'(TICK[0]), 32'(m0[k-1]));
         chk("init_tick1", 32'(TICK[1]), 32'(m1[k-1]));
         chk("init_tick2", 32'(TICK[2]), 32'(m2[k-1]));
         if (k == 4) chk("init_sq0_e4", 32'(SQ[0]), 32'd1);
         if (k == 7) chk("init_sq0_e7", 32'(SQ[0]), 32'd1);
         if (k == 8) chk("init_sq0_e8", 32'(SQ[0]), 32'd0);
      end

      // Ch1 at 5 from a sync point, rewritten to 2 at edge 3.
      wr_pulse(1, 5, 1'b1);
      step(2);
      wr_pulse(1, 2, 1'b0);
      for (int k = 4; k <= 9; k++) begin
         step(1);
         chk("wr_tick1", 32'(TICK[1]), (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      wr_pulse(3, 1, 1'b0);
      step(4);
      wr_pulse(15, 7, 1'b0);
      step(6);

      // Divisor 0 on ch2: ticks every enabled edge, SQ toggles every edge.
      wr_pulse(2, 0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk("div0_tick2", 32'(TICK[2]), 32'd1);
         chk("div0_sq2",   32'(SQ[2]),   (k % 2 == 1) ? 32'd1 : 32'd0);
      end

      // Ch0 at 4, frozen for three edges after edge 2: tick moves to edge 7.
      wr_pulse(0, 4, 1'b1);
      step(2);
      EN = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         step(1);
         chk("frozen_tick", 32'(TICK), 32'd0);
      end
      EN = 1'b1;
      step(1);
      chk("resume_e6_tick0", 32'(TICK[0]), 32'd0);
      step(1);
      chk("resume_e7_tick0", 32'(TICK[0]), 32'd1);

      // SYNC together with WR(ch0,6) mid-period.
      step(2);
      wr_pulse(0, 6, 1'b1);
      chk("sync_tick", 32'(TICK), 32'd0);
      chk("sync_sq",   32'(SQ),   32'd0);
      step(5);
      chk("sync_e5_tick0", 32'(TICK[0]), 32'd0);
      step(1);
      chk("sync_e6_tick0", 32'(TICK[0]), 32'd1);

      // Long divisor on ch0.
      wr_pulse(0, 1000, 1'b1);
      step(1000);
      chk("long_tick0_1000", 32'(TICK[0]), 32'd1);
      chk("long_sq0_1000",   32'(SQ[0]),   32'd1);
      step(500);
      chk("long_sq0_1500",   32'(SQ[0]),   32'd1);
      step(500);
      chk("long_tick0_2000", 32'(TICK[0]), 32'd1);
      chk("long_sq0_2000",   32'(SQ[0]),   32'd0);
      step(3);

      // Asynchronous reset mid-count clears outputs before any clock edge.
      chk("pre_rst_tick2", 32'(TICK[2]), 32'd1);
      RST = 1'b1;
      #1;
      chk("async_rst_tick", 32'(TICK), 32'd0);
      chk("async_rst_sq",   32'(SQ),   32'd0);
      step(2);
      RST = 1'b0;
      step(1);
      chk("post_rst_e1", 32'(TICK), 32'd0);
      step(1);
      chk("post_rst_e2", 32'(TICK), 32'b010);
      step(2);
      chk("post_rst_e4", 32'(TICK), 32'b011);

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
